// File: rtl/acc_pkg.sv
// Shared types for the accelerator job sequencer: decoded descriptor, FSM states
// and the bit positions of each field inside the raw cfg/base words.
package acc_pkg;

    localparam int FIELD_W          = 8;
    localparam int ADDR_W           = 12;
    localparam int CFG_OUT_MODE_BIT = 0;
    localparam int CFG_K_LSB        = 8;
    localparam int CFG_ROW_LSB      = 16;
    localparam int CFG_COL_LSB      = 24;
    localparam int BASE_ROW_LSB     = 0;
    localparam int BASE_COL_LSB     = 16;

    typedef struct packed {
        logic              out_mode;
        logic [FIELD_W-1:0] k_param;
        logic [FIELD_W-1:0] row_shape;
        logic [FIELD_W-1:0] col_shape;
        logic [ADDR_W-1:0]  base_row_addr;
        logic [ADDR_W-1:0]  base_col_addr;
    } acc_desc_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2
    } seq_state_t;

    // Only the meaningful fields are stored, so the queue never holds reserved bits.
    function automatic acc_desc_t decode_desc(input logic [31:0] cfg, input logic [31:0] base);
        acc_desc_t d;
        d.out_mode      = cfg[CFG_OUT_MODE_BIT];
        d.k_param       = cfg[CFG_K_LSB +: FIELD_W];
        d.row_shape     = cfg[CFG_ROW_LSB +: FIELD_W];
        d.col_shape     = cfg[CFG_COL_LSB +: FIELD_W];
        d.base_row_addr = base[BASE_ROW_LSB +: ADDR_W];
        d.base_col_addr = base[BASE_COL_LSB +: ADDR_W];
        return d;
    endfunction

endpackage

// File: rtl/acc_desc_fifo.sv
// Descriptor queue: DEPTH-entry circular buffer with occupancy count and a
// synchronous flush that overrides any push or pop in the same cycle.
module acc_desc_fifo
    import acc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  acc_desc_t                wr_data,
    input  logic                     rd_en,
    output acc_desc_t                rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    acc_desc_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_fire;
    logic             rd_fire;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem[rd_ptr_q];
    assign wr_fire = wr_en && !full && !flush;
    assign rd_fire = rd_en && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({wr_fire, rd_fire})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/acc_job_seq.sv
// Accelerator job sequencer: queues descriptors and launches them one at a time
// onto the array. Optional RUN watchdog enabled by defining ACC_SEQ_TIMEOUT_EN.
module acc_job_seq
    import acc_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    desc_valid,
    output logic                    desc_ready,
    input  logic [31:0]             desc_cfg,
    input  logic [31:0]             desc_base,
    output logic                    start_all,
    output logic                    out_mode,
    output logic [7:0]              k_param,
    output logic [7:0]              row_shape,
    output logic [7:0]              col_shape,
    output logic [11:0]             base_row_addr,
    output logic [11:0]             base_col_addr,
    input  logic                    done_all,
    input  logic                    abort,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  q_count,
`ifdef ACC_SEQ_TIMEOUT_EN
    output logic                    err_timeout,
`endif
    output logic [15:0]             jobs_done,
    output logic                    irq,
    input  logic                    irq_clr
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    seq_state_t       state_q, state_d;
    acc_desc_t        cur_q, cur_d;
    logic             start_all_q, start_all_d;
    logic             busy_q, busy_d;
    logic [15:0]      jobs_done_q, jobs_done_d;
    logic             irq_q, irq_d;
    logic             irq_set;

    acc_desc_t        push_desc;
    acc_desc_t        head_desc;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             flush;
    logic             timeout_hit;

    // Reserved descriptor bits are intentionally ignored.
    logic unused_desc_bits;
    assign unused_desc_bits = ^{desc_cfg[7:1], desc_base[15:12], desc_base[31:28]};

    assign push_desc  = decode_desc(desc_cfg, desc_base);
    assign desc_ready = !fifo_full;
    assign pop        = (state_q == ST_LAUNCH);
    assign flush      = abort || timeout_hit;

    acc_desc_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .wr_en   (desc_valid),
        .wr_data (push_desc),
        .rd_en   (pop),
        .rd_data (head_desc),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef ACC_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] run_cnt_q, run_cnt_d;
    logic            err_timeout_q, err_timeout_d;

    // Fires on the TIMEOUT_CYC-th consecutive RUN cycle; a done_all that cycle still wins.
    assign timeout_hit = (state_q == ST_RUN) && !done_all && (run_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    always_comb begin
        run_cnt_d     = (state_q == ST_RUN) ? run_cnt_q + TO_W'(1) : '0;
        err_timeout_d = err_timeout_q;
        if (timeout_hit)  err_timeout_d = 1'b1;
        else if (irq_clr) err_timeout_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_q     <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            run_cnt_q     <= run_cnt_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
    assign timeout_hit        = 1'b0;
`endif

    // Config and start_all are loaded on the edge that enters LAUNCH, so they
    // are valid throughout the LAUNCH cycle while the head is being popped.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        start_all_d = 1'b0;
        jobs_done_d = jobs_done_q;
        irq_set     = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_d     = ST_LAUNCH;
                        cur_d       = head_desc;
                        start_all_d = 1'b1;
                    end
                end
                ST_LAUNCH: state_d = ST_RUN;
                ST_RUN: begin
                    if (done_all) begin
                        jobs_done_d = jobs_done_q + 16'd1;
                        if (!fifo_empty) begin
                            state_d     = ST_LAUNCH;
                            cur_d       = head_desc;
                            start_all_d = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            irq_set = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        irq_d = irq_q;
        if (!flush) begin
            if (irq_set)      irq_d = 1'b1;
            else if (irq_clr) irq_d = 1'b0;
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            start_all_q <= 1'b0;
            busy_q      <= 1'b0;
            jobs_done_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            start_all_q <= start_all_d;
            busy_q      <= busy_d;
            jobs_done_q <= jobs_done_d;
            irq_q       <= irq_d;
        end
    end

    assign start_all     = start_all_q;
    assign busy          = busy_q;
    assign jobs_done     = jobs_done_q;
    assign irq           = irq_q;
    assign q_count       = fifo_count;
    assign out_mode      = cur_q.out_mode;
    assign k_param       = cur_q.k_param;
    assign row_shape     = cur_q.row_shape;
    assign col_shape     = cur_q.col_shape;
    assign base_row_addr = cur_q.base_row_addr;
    assign base_col_addr = cur_q.base_col_addr;

endmodule

// File: tb/tb_acc_job_seq.sv
// Directed and randomized bench for acc_job_seq against a queue-based reference model.
module tb_acc_job_seq;

    localparam int DEPTH = 4;
`ifdef ACC_SEQ_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 65535;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        desc_valid = 1'b0;
    logic        desc_ready;
    logic [31:0] desc_cfg = '0;
    logic [31:0] desc_base = '0;
    logic        start_all;
    logic        out_mode;
    logic [7:0]  k_param, row_shape, col_shape;
    logic [11:0] base_row_addr, base_col_addr;
    logic        done_all = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic [2:0]  q_count;
    logic [15:0] jobs_done;
    logic        irq;
    logic        irq_clr = 1'b0;
`ifdef ACC_SEQ_TIMEOUT_EN
    logic        err_timeout;
`endif

    always #5 clk = ~clk;

    acc_job_seq #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_cfg(desc_cfg), .desc_base(desc_base),
        .start_all(start_all), .out_mode(out_mode), .k_param(k_param),
        .row_shape(row_shape), .col_shape(col_shape),
        .base_row_addr(base_row_addr), .base_col_addr(base_col_addr),
        .done_all(done_all), .abort(abort), .busy(busy), .q_count(q_count),
`ifdef ACC_SEQ_TIMEOUT_EN
        .err_timeout(err_timeout),
`endif
        .jobs_done(jobs_done), .irq(irq), .irq_clr(irq_clr)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: pending jobs as a queue, current job, counters.
    logic [31:0] mq_cfg[$];
    logic [31:0] mq_base[$];
    int          m_phase;   // 0 idle, 1 launching, 2 running
    logic [31:0] m_cur_cfg, m_cur_base;
    logic        m_start, m_irq, m_err;
    logic [15:0] m_jobs;
    int          m_run;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq_cfg.delete();
        mq_base.delete();
        m_phase = 0; m_cur_cfg = '0; m_cur_base = '0;
        m_start = 0; m_irq = 0; m_err = 0; m_jobs = '0; m_run = 0;
    endtask

    task automatic model_step();
        bit push_ok, timeout, irq_set;
        push_ok = desc_valid && (mq_cfg.size() < DEPTH);
        timeout = 0;
        irq_set = 0;
`ifdef ACC_SEQ_TIMEOUT_EN
        if (m_phase == 2 && !done_all && m_run + 1 == TO) timeout = 1;
        m_run = (m_phase == 2) ? m_run + 1 : 0;
        if (timeout) m_err = 1;
        else if (irq_clr) m_err = 0;
`endif
        m_start = 0;
        if (abort || timeout) begin
            mq_cfg.delete();
            mq_base.delete();
            m_phase = 0;
        end else begin
            if (m_phase == 0) begin
                if (mq_cfg.size() > 0) begin
                    m_phase = 1; m_start = 1;
                    m_cur_cfg = mq_cfg[0]; m_cur_base = mq_base[0];
                end
            end else if (m_phase == 1) begin
                void'(mq_cfg.pop_front());
                void'(mq_base.pop_front());
                m_phase = 2;
            end else if (done_all) begin
                m_jobs = m_jobs + 16'd1;
                if (mq_cfg.size() > 0) begin
                    m_phase = 1; m_start = 1;
                    m_cur_cfg = mq_cfg[0]; m_cur_base = mq_base[0];
                end else begin
                    m_phase = 0; irq_set = 1;
                end
            end
            if (irq_set) m_irq = 1;
            else if (irq_clr) m_irq = 0;
            if (push_ok) begin
                mq_cfg.push_back(desc_cfg);
                mq_base.push_back(desc_base);
            end
        end
    endtask

    task automatic check_all();
        chk("start_all", start_all, m_start);
        chk("busy", busy, m_phase != 0);
        chk("q_count", q_count, mq_cfg.size());
        chk("desc_ready", desc_ready, mq_cfg.size() != DEPTH);
        chk("jobs_done", jobs_done, m_jobs);
        chk("irq", irq, m_irq);
        chk("out_mode", out_mode, m_cur_cfg[0]);
        chk("k_param", k_param, m_cur_cfg[15:8]);
        chk("row_shape", row_shape, m_cur_cfg[23:16]);
        chk("col_shape", col_shape, m_cur_cfg[31:24]);
        chk("base_row", base_row_addr, m_cur_base[11:0]);
        chk("base_col", base_col_addr, m_cur_base[27:16]);
`ifdef ACC_SEQ_TIMEOUT_EN
        chk("err_timeout", err_timeout, m_err);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_start"}, start_all, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_qcnt"}, q_count, 0);
        chk({tag, "_ready"}, desc_ready, 1);
        chk({tag, "_jobs"}, jobs_done, 0);
        chk({tag, "_irq"}, irq, 0);
        chk({tag, "_cfg"}, {out_mode, k_param, row_shape, col_shape}, 0);
        chk({tag, "_base"}, {base_row_addr, base_col_addr}, 0);
    endtask

    task automatic wait_run(input string tag);
        int g = 0;
        while (m_phase != 2 && g < 8) begin cycle(); g++; end
        chk({tag, "_reach_run"}, m_phase, 2);
    endtask

    initial begin
        logic [15:0] saved_jobs;
        int pushed, guard;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Single descriptor: start_all two cycles after the push handshake.
        desc_valid = 1; desc_cfg = 32'h10080801; desc_base = 32'h00200100;
        cycle();
        desc_valid = 0;
        chk("req031_n1_start", start_all, 0);
        cycle();
        chk("req031_n2_start", start_all, 1);
        chk("req031_k", k_param, 8'h08);
        chk("req031_row", row_shape, 8'h08);
        chk("req031_col", col_shape, 8'h10);
        chk("req031_brow", base_row_addr, 12'h100);
        chk("req031_bcol", base_col_addr, 12'h020);
        cycle();
        cycle();
        done_all = 1; cycle(); done_all = 0;
        chk("req031_jobs", jobs_done, 1);
        chk("req031_irq", irq, 1);
        chk("req031_busy", busy, 0);
        irq_clr = 1; cycle(); irq_clr = 0;
        chk("irqclr_alone", irq, 0);

        // Five descriptors into a stalled array: queue fills, order kept.
        pushed = 0; guard = 0;
        while (pushed < 5 && guard < 40) begin
            bit will;
            desc_valid = 1;
            desc_cfg = 32'(pushed + 1) << 8;
            desc_base = 32'(pushed * 3);
            will = (mq_cfg.size() < DEPTH);
            cycle();
            if (will) pushed++;
            guard++;
        end
        desc_valid = 0;
        chk("req032_pushed", pushed, 5);
        chk("req032_full_ready", desc_ready, 0);
        chk("req032_full_qcnt", q_count, 4);
        for (int j = 1; j <= 5; j++) begin
            wait_run("req032");
            chk("req032_order", k_param, j);
            done_all = 1; cycle(); done_all = 0;
        end
        chk("req032_jobs", jobs_done, 6);
        irq_clr = 1; cycle(); irq_clr = 0;

        // done_all during LAUNCH is ignored.
        desc_valid = 1; desc_cfg = 32'h0000_2200; cycle(); desc_valid = 0;
        cycle();
        chk("req033_launch", start_all, 1);
        done_all = 1; cycle(); done_all = 0;
        chk("req033_still_busy", busy, 1);
        chk("req033_jobs", jobs_done, 6);
        done_all = 1; cycle(); done_all = 0;
        chk("req033_done", busy, 0);

        // Abort in RUN with two jobs pending.
        for (int j = 0; j < 3; j++) begin
            desc_valid = 1; desc_cfg = 32'(j + 9) << 8; cycle();
        end
        desc_valid = 0;
        wait_run("req034");
        chk("req034_pending", q_count, 2);
        saved_jobs = m_jobs;
        abort = 1; desc_valid = 1; cycle(); abort = 0; desc_valid = 0;
        chk("req034_qcnt", q_count, 0);
        chk("req034_busy", busy, 0);
        for (int j = 0; j < 3; j++) begin
            cycle();
            chk("req034_no_start", start_all, 0);
        end
        chk("req034_jobs", jobs_done, saved_jobs);

        // irq set wins over simultaneous clear.
        irq_clr = 1; cycle(); irq_clr = 0;
        desc_valid = 1; desc_cfg = 32'h0000_3300; cycle(); desc_valid = 0;
        wait_run("req035");
        done_all = 1; irq_clr = 1; cycle(); done_all = 0; irq_clr = 0;
        chk("req035_set_wins", irq, 1);
        irq_clr = 1; cycle(); irq_clr = 0;
        chk("req035_clear", irq, 0);

`ifdef ACC_SEQ_TIMEOUT_EN
        desc_valid = 1; desc_cfg = 32'h0000_4400; cycle(); desc_valid = 0;
        repeat (TO + 4) cycle();
        chk("timeout_err", err_timeout, 1);
        chk("timeout_idle", busy, 0);
        irq_clr = 1; cycle(); irq_clr = 0;
        chk("timeout_clr", err_timeout, 0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            desc_valid = 1'($urandom_range(0, 1));
            desc_cfg   = $urandom;
            desc_base  = $urandom;
            done_all   = ($urandom_range(0, 3) == 0);
            abort      = ($urandom_range(0, 60) == 0);
            irq_clr    = ($urandom_range(0, 12) == 0);
            cycle();
        end
        desc_valid = 0; done_all = 0; abort = 0; irq_clr = 0;

        // Asynchronous reset in the middle of a job.
        desc_valid = 1; desc_cfg = 32'h0505_0501; desc_base = 32'h0fff_0fff; cycle(); desc_valid = 0;
        wait_run("async");
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
